// File: rtl/i2s_tx_framer.sv
// I2S transmit framer: buffers stereo PCM pairs in a small FIFO and presents one
// left-justified 32-bit word per half-frame, with the word-select clock derived from the bit clock.
module i2s_tx_framer #(
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SAMPLE_W-1:0]       in_left,
    input  logic [SAMPLE_W-1:0]       in_right,
    output logic                      lr_clk,
    output logic [31:0]               bit_data,
    output logic                      frame_start,
    output logic                      underrun,
    output logic [15:0]               underrun_cnt,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned EW  = 2 * SAMPLE_W;
    localparam int unsigned PAD = 32 - SAMPLE_W;

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [15:0]   CNT_MAX    = 16'hFFFF;

    // Sample sits in the top bits of the word; no sign extension into the pad.
    function automatic logic [31:0] fmt_word(input logic [SAMPLE_W-1:0] s);
        logic [31:0] w;
        w = 32'(s);
        return w << PAD;
    endfunction

    // ---------------------------------------------------------------------
    // FIFO storage and pointers
    // ---------------------------------------------------------------------
    logic [EW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q,  level_d;

    logic                push;
    logic                pop;
    logic                empty;
    logic [EW-1:0]       rd_entry;
    logic [SAMPLE_W-1:0] rd_left;
    logic [SAMPLE_W-1:0] rd_right;

    assign empty    = (level_q == '0);
    assign in_ready = (level_q != FULL_LEVEL);
    assign push     = in_valid && in_ready;
    assign rd_entry = mem_q[rd_ptr_q];
    assign rd_left  = rd_entry[EW-1:SAMPLE_W];
    assign rd_right = rd_entry[SAMPLE_W-1:0];

    // Contents need no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_left, in_right};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // ---------------------------------------------------------------------
    // Frame counter, word select and word load
    // ---------------------------------------------------------------------
    logic [4:0]          bit_cnt_q,      bit_cnt_d;
    logic                lr_clk_q,       lr_clk_d;
    logic [31:0]         bit_data_q,     bit_data_d;
    logic                frame_start_q,  frame_start_d;
    logic                underrun_q,     underrun_d;
    logic [15:0]         underrun_cnt_q, underrun_cnt_d;
    logic [SAMPLE_W-1:0] r_hold_q,       r_hold_d;

    logic                boundary;

    assign boundary = en && (bit_cnt_q == 5'd31);

    always_comb begin
        bit_cnt_d      = bit_cnt_q;
        lr_clk_d       = lr_clk_q;
        bit_data_d     = bit_data_q;
        r_hold_d       = r_hold_q;
        underrun_cnt_d = underrun_cnt_q;
        frame_start_d  = 1'b0;
        underrun_d     = 1'b0;
        pop            = 1'b0;

        if (en) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
        end

        if (boundary) begin
            lr_clk_d = ~lr_clk_q;
            if (lr_clk_q) begin
                // Leaving the right half-frame: this edge starts a new left word.
                frame_start_d = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    bit_data_d = fmt_word(rd_left);
                    r_hold_d   = rd_right;
                end else begin
                    bit_data_d = '0;
                    r_hold_d   = '0;
                    underrun_d = 1'b1;
                    if (underrun_cnt_q != CNT_MAX) begin
                        underrun_cnt_d = underrun_cnt_q + 16'd1;
                    end
                end
            end else begin
                bit_data_d = fmt_word(r_hold_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            bit_cnt_q      <= '0;
            lr_clk_q       <= 1'b1;
            bit_data_q     <= '0;
            frame_start_q  <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
            r_hold_q       <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            bit_cnt_q      <= bit_cnt_d;
            lr_clk_q       <= lr_clk_d;
            bit_data_q     <= bit_data_d;
            frame_start_q  <= frame_start_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
            r_hold_q       <= r_hold_d;
        end
    end

    assign lr_clk       = lr_clk_q;
    assign bit_data     = bit_data_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;
    assign fifo_level   = level_q;

endmodule

// File: tb/tb_i2s_tx_framer.sv
// Directed bench for i2s_tx_framer: boundary timing, underrun handling, back-pressure,
// enable hold and mid-frame reset.
module tb_i2s_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_left;
    logic [23:0] in_right;
    logic        lr_clk;
    logic [31:0] bit_data;
    logic        frame_start;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    i2s_tx_framer #(
        .SAMPLE_W (24),
        .DEPTH    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_left      (in_left),
        .in_right     (in_right),
        .lr_clk       (lr_clk),
        .bit_data     (bit_data),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at a falling edge with rst low; the next rising edge is cycle 1.
    task automatic do_reset(input logic en_after);
        rst      = 1'b1;
        en       = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;
        tick(2);
        rst = 1'b0;
        en  = en_after;
    endtask

    initial begin
        // Reset values
        do_reset(1'b0);
        check("rst_lr", 32'(lr_clk), 32'd1);
        check("rst_data", bit_data, 32'h0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_ucnt", 32'(underrun_cnt), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_ur", 32'(underrun), 32'd0);

        // Single pair pushed at cycle 2
        do_reset(1'b1);
        tick(1);
        in_valid = 1'b1;
        in_left  = 24'h123456;
        in_right = 24'hABCDEF;
        tick(1);
        in_valid = 1'b0;
        check("t1_level1", 32'(fifo_level), 32'd1);
        tick(29);
        check("t1_lr_pre", 32'(lr_clk), 32'd1);
        tick(1);
        check("t1_lr32", 32'(lr_clk), 32'd0);
        check("t1_data32", bit_data, 32'h12345600);
        check("t1_fs32", 32'(frame_start), 32'd1);
        check("t1_ur32", 32'(underrun), 32'd0);
        check("t1_level32", 32'(fifo_level), 32'd0);
        tick(1);
        check("t1_fs33", 32'(frame_start), 32'd0);
        tick(31);
        check("t1_lr64", 32'(lr_clk), 32'd1);
        check("t1_data64", bit_data, 32'hABCDEF00);
        check("t1_fs64", 32'(frame_start), 32'd0);

        // Never push: every left boundary underruns
        do_reset(1'b1);
        tick(32);
        check("t2_ur32", 32'(underrun), 32'd1);
        check("t2_fs32", 32'(frame_start), 32'd1);
        check("t2_data32", bit_data, 32'h0);
        check("t2_cnt32", 32'(underrun_cnt), 32'd1);
        tick(1);
        check("t2_ur33", 32'(underrun), 32'd0);
        tick(63);
        check("t2_cnt96", 32'(underrun_cnt), 32'd2);
        check("t2_ur96", 32'(underrun), 32'd1);
        tick(64);
        check("t2_cnt160", 32'(underrun_cnt), 32'd3);
        check("t2_data160", bit_data, 32'h0);

        // Back-pressure: fill with en low, fifth pair waits for a pop
        do_reset(1'b0);
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_left  = 24'(24'h100000 + i);
            in_right = 24'(24'h200000 + i);
            tick(1);
        end
        check("t3_level4", 32'(fifo_level), 32'd4);
        check("t3_ready0", 32'(in_ready), 32'd0);
        in_left  = 24'h100005;
        in_right = 24'h200005;
        tick(3);
        check("t3_level_hold", 32'(fifo_level), 32'd4);
        check("t3_data_hold", bit_data, 32'h0);
        check("t3_lr_hold", 32'(lr_clk), 32'd1);
        en = 1'b1;
        tick(32);
        check("t3_pop_level", 32'(fifo_level), 32'd3);
        check("t3_pop_ready", 32'(in_ready), 32'd1);
        check("t3_pop_data", bit_data, 32'h10000100);
        tick(1);
        in_valid = 1'b0;
        check("t3_refill", 32'(fifo_level), 32'd4);
        tick(31);
        check("t3_right1", bit_data, 32'h20000100);

        // Push on the left-boundary edge with the FIFO empty
        do_reset(1'b1);
        tick(31);
        in_valid = 1'b1;
        in_left  = 24'h0A0B0C;
        in_right = 24'h0D0E0F;
        tick(1);
        in_valid = 1'b0;
        check("t4_ur", 32'(underrun), 32'd1);
        check("t4_data0", bit_data, 32'h0);
        check("t4_level", 32'(fifo_level), 32'd1);
        tick(32);
        check("t4_right0", bit_data, 32'h0);
        tick(32);
        check("t4_left96", bit_data, 32'h0A0B0C00);
        check("t4_ur96", 32'(underrun), 32'd0);
        check("t4_fs96", 32'(frame_start), 32'd1);
        tick(32);
        check("t4_right128", bit_data, 32'h0D0E0F00);

        // Enable held low for 10 cycles at bit_cnt=20
        do_reset(1'b1);
        in_valid = 1'b1;
        in_left  = 24'h111111;
        in_right = 24'h222222;
        tick(1);
        in_valid = 1'b0;
        tick(31);
        check("t5_left", bit_data, 32'h11111100);
        tick(20);
        en = 1'b0;
        tick(10);
        check("t5_hold_data", bit_data, 32'h11111100);
        check("t5_hold_lr", 32'(lr_clk), 32'd0);
        en = 1'b1;
        tick(11);
        check("t5_not_yet", 32'(lr_clk), 32'd0);
        check("t5_not_yet_d", bit_data, 32'h11111100);
        tick(1);
        check("t5_lr_late", 32'(lr_clk), 32'd1);
        check("t5_right", bit_data, 32'h22222200);

        // Reset mid-frame with three pairs queued
        do_reset(1'b1);
        tick(32);
        check("t6_pre_cnt", 32'(underrun_cnt), 32'd1);
        en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_left  = 24'(24'h300000 + i);
            in_right = 24'(24'h400000 + i);
            tick(1);
        end
        in_valid = 1'b0;
        check("t6_level3", 32'(fifo_level), 32'd3);
        en = 1'b1;
        tick(15);
        rst = 1'b1;
        tick(1);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_lr", 32'(lr_clk), 32'd1);
        check("t6_data", bit_data, 32'h0);
        check("t6_cnt", 32'(underrun_cnt), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick(32);
        check("t6_post_ur", 32'(underrun), 32'd1);
        check("t6_post_data", bit_data, 32'h0);
        check("t6_post_cnt", 32'(underrun_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
